// File: rtl/alu_wide_sequencer_if.sv
// alu_wide_sequencer_if
//   Bundles the three buses of the wide ALU sequencer:
//     req_*  : wide operation request (valid/ready), driven by the requester
//     rsp_*  : wide result response (valid/ready), consumed by the requester
//     alu_*  : one-word-per-cycle link to the 32-bit ALU beside the sequencer
//   slave  : sequencer view (accepts requests, drives the ALU, returns results)
//   master : requester/ALU view
interface alu_wide_sequencer_if #(
  parameter int WORDS = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [2:0]             req_opcode;
  logic [32*WORDS-1:0]    req_a;
  logic [32*WORDS-1:0]    req_b;
  logic                   req_cin;

  logic [2:0]             alu_opcode;
  logic [31:0]            alu_a;
  logic [31:0]            alu_b;
  logic                   alu_cin;
  logic [31:0]            alu_result;
  logic                   alu_cout;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [32*WORDS-1:0]    rsp_result;
  logic                   rsp_cout;
  logic                   rsp_err;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_cin,
    input  alu_result, alu_cout,
    input  rsp_ready,
    output req_ready,
    output alu_opcode, alu_a, alu_b, alu_cin,
    output rsp_valid, rsp_result, rsp_cout, rsp_err
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, req_cin,
    output alu_result, alu_cout,
    output rsp_ready,
    input  req_ready,
    input  alu_opcode, alu_a, alu_b, alu_cin,
    input  rsp_valid, rsp_result, rsp_cout, rsp_err
  );
endinterface

// File: rtl/alu_wide_sequencer.sv
// alu_wide_sequencer
//   Multi-precision front end for a 32-bit ALU. Latches one WORDS x 32-bit
//   operation, feeds it to the ALU one word per cycle (LSW first), chains the
//   carry for ADD and returns the assembled wide result.
//   Ports:
//     clk  : clock, rising edge
//     rst  : synchronous reset, active high
//     bus  : alu_wide_sequencer_if.slave (req_*, rsp_*, alu_* buses)
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   RUN   | issuing word r_idx to the ALU, capturing its result
//   DONE  | response valid, holding until rsp_ready
module alu_wide_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_wide_sequencer_if.slave  bus
);
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_NOT = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b111;

  logic [1:0]          r_state;
  logic [IDXW-1:0]     r_idx;
  logic                r_carry;
  logic                r_err;
  logic [2:0]          r_op;
  logic [32*WORDS-1:0] r_a;
  logic [32*WORDS-1:0] r_b;
  logic [32*WORDS-1:0] r_result;

  logic                w_accept;
  logic                w_supported;
  logic                w_is_add;
  logic                w_last;
  logic [IDXW+4:0]     w_base;

  assign w_supported = (bus.req_opcode == OP_NOT) || (bus.req_opcode == OP_AND) ||
                       (bus.req_opcode == OP_OR)  || (bus.req_opcode == OP_XOR) ||
                       (bus.req_opcode == OP_ADD);
  assign w_accept    = bus.req_valid && bus.req_ready;
  assign w_is_add    = (r_op == OP_ADD);
  assign w_last      = (r_idx == IDXW'(WORDS - 1));
  // bit offset of the active word
  assign w_base      = {r_idx, 5'b0};

  always_comb begin
    bus.req_ready  = (r_state == S_IDLE) && !rst;
    bus.rsp_valid  = (r_state == S_DONE);
    bus.rsp_result = r_result;
    bus.rsp_cout   = r_carry;
    bus.rsp_err    = r_err;
    bus.alu_opcode = 3'b000;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_cin    = 1'b0;
    if (r_state == S_RUN) begin
      bus.alu_opcode = r_op;
      bus.alu_a      = r_a[w_base +: 32];
      bus.alu_b      = r_b[w_base +: 32];
      bus.alu_cin    = w_is_add ? r_carry : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_err    <= 1'b0;
      r_op     <= 3'b000;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= bus.req_opcode;
            r_a      <= bus.req_a;
            r_b      <= bus.req_b;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= (bus.req_opcode == OP_ADD) ? bus.req_cin : 1'b0;
            // unsupported ops skip the ALU and report straight away
            r_err    <= !w_supported;
            r_state  <= w_supported ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          r_result[w_base +: 32] <= bus.alu_result;
          r_carry                <= w_is_add ? bus.alu_cout : 1'b0;
          if (w_last) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (bus.rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_wide_sequencer.sv
// tb_alu_wide_sequencer
//   Bench for alu_wide_sequencer with WORDS=4 and a behavioural 32-bit ALU.
//   Expected wide results come from a whole-width reference model and are
//   queued at request time, then popped when the response appears.
module tb_alu_wide_sequencer;
  localparam int W = 4;
  typedef logic [32*W-1:0] wide_t;
  typedef struct packed {
    wide_t result;
    logic  cout;
    logic  err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_wide_sequencer_if #(.WORDS(W)) bus ();

  alu_wide_sequencer #(.WORDS(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 32-bit ALU beside the sequencer
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {32'b0, bus.alu_cin};
    bus.alu_cout = 1'b0;
    case (bus.alu_opcode)
      3'b000:  bus.alu_result = ~bus.alu_a;
      3'b001:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a | bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b111: begin
        bus.alu_result = alu_sum[31:0];
        bus.alu_cout   = alu_sum[32];
      end
      default: bus.alu_result = 32'h0;
    endcase
  end

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  function automatic exp_t model(input logic [2:0] op, input wide_t a, input wide_t b,
                                 input logic cin);
    exp_t e;
    logic [32*W:0] s;
    e = '0;
    s = '0;
    case (op)
      3'b000: e.result = ~a;
      3'b001: e.result = a & b;
      3'b010: e.result = a | b;
      3'b011: e.result = a ^ b;
      3'b111: begin
        s = {1'b0, a} + {1'b0, b} + {{(32*W){1'b0}}, cin};
        e.result = s[32*W-1:0];
        e.cout   = s[32*W];
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction

  function automatic wide_t rand_wide();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Drives a request until accepted; ends #1 into cycle 1 (accept = cycle 0).
  task automatic send(input logic [2:0] op, input wide_t a, input wide_t b,
                      input logic cin, output int waited);
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_cin    = cin;
    waited = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        waited = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (waited < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: req_ready never seen, got 0 required 1");
    end else begin
      exp_q.push_back(model(op, a, b, cin));
    end
  endtask

  // Waits for rsp_valid starting at cycle 'first'; captures outputs and steps
  // past the following rising edge.
  task automatic wait_rsp(input int first, output wide_t res, output logic cout,
                          output logic err, output int cyc);
    cyc  = -1;
    res  = '0;
    cout = 1'b0;
    err  = 1'b0;
    for (int c = first; c < first + 60; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        cyc  = c;
        res  = bus.rsp_result;
        cout = bus.rsp_cout;
        err  = bus.rsp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: rsp_valid never seen, got 0 required 1");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_req_ready: got %b required 0", bus.req_ready);
    end
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_cout, bus.rsp_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_rsp_flags: got %b required 000",
                         {bus.rsp_valid, bus.rsp_cout, bus.rsp_err});
    end
    n_checks++;
    if (bus.rsp_result !== '0) begin
      n_fail++; $display("FAIL reset_rsp_result: got %h required 0", bus.rsp_result);
    end
    n_checks++;
    if ({bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_cin} !== '0) begin
      n_fail++; $display("FAIL reset_alu_idle: got op %b a %h b %h cin %b required all 0",
                         bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_cin);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b required 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_add_ripple();
    int    waited, cyc;
    wide_t res;
    logic  cout, err;
    logic [3:0] cin_seq;
    exp_t  e;
    send(3'b111, {W{32'hFFFF_FFFF}}, wide_t'(1), 1'b0, waited);
    cin_seq = '0;
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      cin_seq = {cin_seq[2:0], bus.alu_cin};
    end
    n_checks++;
    if (cin_seq !== 4'b0111) begin
      n_fail++; $display("FAIL ripple_alu_cin_seq: got %b required 0111", cin_seq);
    end
    wait_rsp(W + 1, res, cout, err, cyc);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    n_checks++;
    if ({res, cout, err} !== {e.result, e.cout, e.err}) begin
      n_fail++; $display("FAIL ripple_result: got %h cout %b err %b required %h cout %b err %b",
                         res, cout, err, e.result, e.cout, e.err);
    end
    n_checks++;
    if (cyc !== W + 1) begin
      n_fail++; $display("FAIL ripple_latency: got cycle %0d required %0d", cyc, W + 1);
    end
  endtask

  task automatic test_add_cin();
    int    waited, cyc;
    wide_t res;
    logic  cout, err;
    exp_t  e;
    send(3'b111, wide_t'(32'hFFFF_FFFF), '0, 1'b1, waited);
    wait_rsp(1, res, cout, err, cyc);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    n_checks++;
    if ({res, cout, err} !== {e.result, e.cout, e.err}) begin
      n_fail++; $display("FAIL add_cin_result: got %h cout %b err %b required %h cout %b err %b",
                         res, cout, err, e.result, e.cout, e.err);
    end
    n_checks++;
    if (cyc !== W + 1) begin
      n_fail++; $display("FAIL add_cin_latency: got cycle %0d required %0d", cyc, W + 1);
    end
  endtask

  task automatic test_bitwise();
    int         waited, cyc;
    wide_t      res, a, b;
    logic       cout, err;
    exp_t       e;
    logic [2:0] ops [4];
    ops = '{3'b011, 3'b000, 3'b001, 3'b010};
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        a = {W{32'hAAAA_AAAA}}; b = {W{32'hFFFF_FFFF}};
      end else if (k == 1) begin
        a = '0; b = rand_wide();
      end else begin
        a = rand_wide(); b = rand_wide();
      end
      send(ops[k], a, b, 1'b1, waited);
      wait_rsp(1, res, cout, err, cyc);
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      n_checks++;
      if ({res, cout, err} !== {e.result, e.cout, e.err}) begin
        n_fail++; $display("FAIL bitwise_op%b: got %h cout %b err %b required %h cout %b err %b",
                           ops[k], res, cout, err, e.result, e.cout, e.err);
      end
    end
  endtask

  task automatic test_unsupported();
    int         waited;
    exp_t       e;
    logic [2:0] ops [3];
    ops = '{3'b101, 3'b100, 3'b110};
    for (int k = 0; k < 3; k++) begin
      send(ops[k], rand_wide(), rand_wide(), 1'b1, waited);
      @(negedge clk);
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      n_checks++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_cout, bus.rsp_result} !==
          {1'b1, e.err, e.cout, e.result}) begin
        n_fail++; $display("FAIL unsup_op%b_rsp: got valid %b err %b cout %b res %h required 1 %b %b %h",
                           ops[k], bus.rsp_valid, bus.rsp_err, bus.rsp_cout, bus.rsp_result,
                           e.err, e.cout, e.result);
      end
      n_checks++;
      if (bus.alu_opcode !== 3'b000) begin
        n_fail++; $display("FAIL unsup_alu_opcode: got %b required 000", bus.alu_opcode);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure();
    int    waited, cyc, bad;
    wide_t res, a2, b2;
    logic  cout, err;
    exp_t  e;
    bus.rsp_ready = 1'b0;
    send(3'b111, rand_wide(), rand_wide(), 1'b1, waited);
    wait_rsp(1, res, cout, err, cyc);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    n_checks++;
    if ({res, cout, err} !== {e.result, e.cout, e.err}) begin
      n_fail++; $display("FAIL bp_first_result: got %h cout %b required %h cout %b",
                         res, cout, e.result, e.cout);
    end
    a2 = rand_wide();
    b2 = rand_wide();
    bus.req_valid  = 1'b1;
    bus.req_opcode = 3'b001;
    bus.req_a      = a2;
    bus.req_b      = b2;
    bus.req_cin    = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(bus.rsp_valid === 1'b1 && bus.rsp_result === res && bus.rsp_cout === cout &&
            bus.rsp_err === err && bus.req_ready === 1'b0)) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bp_hold_stable: got %0d unstable cycles required 0", bad);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_ready_after_handshake: got %b required 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    exp_q.push_back(model(3'b001, a2, b2, 1'b0));
    wait_rsp(1, res, cout, err, cyc);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    n_checks++;
    if ({res, cout, err} !== {e.result, e.cout, e.err}) begin
      n_fail++; $display("FAIL bp_second_result: got %h required %h", res, e.result);
    end
    n_checks++;
    if (cyc !== W + 1) begin
      n_fail++; $display("FAIL bp_second_latency: got cycle %0d required %0d", cyc, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    int         waited, cyc;
    wide_t      res;
    logic       cout, err;
    exp_t       e;
    logic [2:0] ops [5];
    ops = '{3'b111, 3'b111, 3'b011, 3'b111, 3'b010};
    for (int k = 0; k < 5; k++) begin
      send(ops[k], rand_wide(), rand_wide(), 1'($urandom_range(1)), waited);
      if (k > 0) begin
        n_checks++;
        if (waited !== 0) begin
          n_fail++; $display("FAIL b2b_accept_wait: got %0d cycles required 0", waited);
        end
      end
      wait_rsp(1, res, cout, err, cyc);
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      n_checks++;
      if ({res, cout, err} !== {e.result, e.cout, e.err}) begin
        n_fail++; $display("FAIL b2b_result_%0d: got %h cout %b required %h cout %b",
                           k, res, cout, e.result, e.cout);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int    waited, seen;
    wide_t a, b;
    a = {W{32'h1234_5678}};
    b = {W{32'h1111_1111}};
    send(3'b111, a, b, 1'b0, waited);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.alu_a !== a[64 +: 32] || bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_run_word2: got alu_a %h ready %b required %h 0",
                         bus.alu_a, bus.req_ready, a[64 +: 32]);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.req_ready, bus.alu_opcode} !== 5'b01_000) begin
      n_fail++; $display("FAIL rst_run_idle: got valid %b ready %b alu_op %b required 0 1 000",
                         bus.rsp_valid, bus.req_ready, bus.alu_opcode);
    end
    n_checks++;
    if (bus.rsp_result !== '0) begin
      n_fail++; $display("FAIL rst_run_result: got %h required 0", bus.rsp_result);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_run_no_rsp: got %0d valid cycles required 0", seen);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_opcode = 3'b000;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_cin    = 1'b0;
    bus.rsp_ready  = 1'b1;
    test_reset();
    test_add_ripple();
    test_add_cin();
    test_bitwise();
    test_unsupported();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
